// File: rtl/memory_access_controller.sv
// memory_access_controller
// Sequences single read/write requests to a latch-based memory as
// setup -> strobe -> hold so the select strobe never overlaps a change of
// address, op or data. Optionally clears every word after reset.
module memory_access_controller #(
    parameter int                 ADDR_W        = 3,
    parameter int                 DATA_W        = 8,
    parameter int                 SETUP_CYCLES  = 1,
    parameter int                 PULSE_CYCLES  = 1,
    parameter int                 INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0]  INIT_VALUE    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              mem_op,
    output logic              mem_select,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in_bus,
    input  logic [DATA_W-1:0] mem_out_bus
);

    localparam int CNT_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_STROBE,
        INIT_HOLD,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W:0]   init_addr_reg, init_addr_next;
    logic [ADDR_W:0]   init_addr_inc;
    logic              req_ready_next, resp_valid_next, init_done_next;
    logic              mem_op_next, mem_select_next;
    logic [ADDR_W-1:0] mem_address_next;
    logic [DATA_W-1:0] mem_in_bus_next, resp_rdata_next;

    assign init_addr_inc = init_addr_reg + 1'b1;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        init_addr_next   = init_addr_reg;
        req_ready_next   = 1'b0;
        resp_valid_next  = 1'b0;
        resp_rdata_next  = resp_rdata;
        init_done_next   = init_done;
        mem_op_next      = mem_op;
        mem_select_next  = 1'b0;
        mem_address_next = mem_address;
        mem_in_bus_next  = mem_in_bus;

        case (state_reg)
            INIT_SETUP: begin
                mem_op_next      = 1'b1;
                mem_address_next = init_addr_reg[ADDR_W-1:0];
                mem_in_bus_next  = INIT_VALUE;
                // Straight out of reset the bus still carries the reset value
                // (op=0); the setup count starts only once the write is on it.
                if (mem_op) begin
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_next        = '0;
                        mem_select_next = 1'b1;
                        state_next      = INIT_STROBE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            INIT_STROBE: begin
                mem_select_next = 1'b1;
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next        = '0;
                    mem_select_next = 1'b0;
                    state_next      = INIT_HOLD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            INIT_HOLD: begin
                init_addr_next = init_addr_inc;
                if (init_addr_inc[ADDR_W]) begin
                    state_next     = IDLE;
                    req_ready_next = 1'b1;
                    init_done_next = 1'b1;
                end else begin
                    mem_address_next = init_addr_inc[ADDR_W-1:0];
                    state_next       = INIT_SETUP;
                end
            end
            IDLE: begin
                req_ready_next = 1'b1;
                init_done_next = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_next   = 1'b0;
                    mem_op_next      = req_write;
                    mem_address_next = req_addr;
                    mem_in_bus_next  = req_wdata;
                    cnt_next         = '0;
                    state_next       = SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    cnt_next        = '0;
                    mem_select_next = 1'b1;
                    state_next      = STROBE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STROBE: begin
                mem_select_next = 1'b1;
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next        = '0;
                    mem_select_next = 1'b0;
                    resp_rdata_next = mem_op ? mem_in_bus : mem_out_bus;
                    state_next      = HOLD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                resp_valid_next = 1'b1;
                state_next      = RESP;
            end
            RESP: begin
                resp_valid_next = 1'b1;
                if (resp_valid && resp_ready) begin
                    resp_valid_next = 1'b0;
                    req_ready_next  = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset drops select immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_ON_RESET != 0) state_reg <= INIT_SETUP;
            else                    state_reg <= IDLE;
            cnt_reg       <= '0;
            init_addr_reg <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            init_done     <= 1'b0;
            mem_op        <= 1'b0;
            mem_select    <= 1'b0;
            mem_address   <= '0;
            mem_in_bus    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            init_addr_reg <= init_addr_next;
            req_ready     <= req_ready_next;
            resp_valid    <= resp_valid_next;
            resp_rdata    <= resp_rdata_next;
            init_done     <= init_done_next;
            mem_op        <= mem_op_next;
            mem_select    <= mem_select_next;
            mem_address   <= mem_address_next;
            mem_in_bus    <= mem_in_bus_next;
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// Testbench for memory_access_controller: two instances (default timing and
// SETUP=2/PULSE=3), each with a latch-style memory model and a bus monitor.
module tb_memory_access_controller;

    localparam logic [7:0] INIT_VAL = 8'h00;

    logic clk;
    logic rst_n;
    logic [1:0]      req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [1:0]      init_done, mem_op, mem_select;
    logic [1:0][2:0] req_addr, mem_address;
    logic [1:0][7:0] req_wdata, resp_rdata, mem_in_bus, mem_out_bus;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int s_of [2] = '{1, 2};
    int p_of [2] = '{1, 3};

    logic [7:0]  mem_model [2][8];
    logic [7:0]  ref_mem   [2][8];
    logic [11:0] plog0 [$];
    logic [11:0] plog1 [$];
    logic [1:0]       prev_sel;
    logic [1:0][11:0] prev_bus;
    logic             mon_en;

    memory_access_controller u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .init_done(init_done[0]), .mem_op(mem_op[0]), .mem_select(mem_select[0]),
        .mem_address(mem_address[0]), .mem_in_bus(mem_in_bus[0]), .mem_out_bus(mem_out_bus[0])
    );

    memory_access_controller #(.SETUP_CYCLES(2), .PULSE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .init_done(init_done[1]), .mem_op(mem_op[1]), .mem_select(mem_select[1]),
        .mem_address(mem_address[1]), .mem_in_bus(mem_in_bus[1]), .mem_out_bus(mem_out_bus[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory drives out_bus only during a read strobe.
    assign mem_out_bus[0] = (mem_select[0] && !mem_op[0]) ? mem_model[0][mem_address[0]] : 8'h00;
    assign mem_out_bus[1] = (mem_select[1] && !mem_op[1]) ? mem_model[1][mem_address[1]] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model writes, strobe log, and bus-stability monitor.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_en && (mem_select[i] || prev_sel[i]))
                chk("bus_stable", {mem_address[i], mem_op[i], mem_in_bus[i]}, prev_bus[i]);
            if (mem_select[i] && !prev_sel[i]) begin
                if (i == 0) plog0.push_back({1'b0, mem_address[i], mem_op[i], mem_in_bus[i]});
                else        plog1.push_back({1'b0, mem_address[i], mem_op[i], mem_in_bus[i]});
            end
            if (mem_select[i] && mem_op[i]) mem_model[i][mem_address[i]] = mem_in_bus[i];
            prev_sel[i] = mem_select[i];
            prev_bus[i] = {mem_address[i], mem_op[i], mem_in_bus[i]};
        end
    end

    task automatic chk_zero(input int i);
        chk("rst_req_ready",  req_ready[i],   0);
        chk("rst_resp_valid", resp_valid[i],  0);
        chk("rst_resp_rdata", resp_rdata[i],  0);
        chk("rst_init_done",  init_done[i],   0);
        chk("rst_mem_op",     mem_op[i],      0);
        chk("rst_mem_select", mem_select[i],  0);
        chk("rst_mem_addr",   mem_address[i], 0);
        chk("rst_mem_in_bus", mem_in_bus[i],  0);
    endtask

    // Wait for both sweeps; req_ready must stay low until init_done.
    task automatic wait_init();
        int k;
        for (int i = 0; i < 2; i++) begin
            k = 0;
            while (init_done[i] !== 1'b1 && k < 300) begin
                chk("init_ready_low", req_ready[i], 0);
                @(posedge clk); #1;
                k++;
            end
            chk("init_timeout", init_done[i], 1);
            chk("init_ready_high", req_ready[i], 1);
            for (int a = 0; a < 8; a++) ref_mem[i][a] = INIT_VAL;
        end
    endtask

    // One strobe per word, ascending, each a write of the fill value.
    task automatic chk_plog(input int i);
        logic [11:0] q [$];
        if (i == 0) q = plog0; else q = plog1;
        chk("init_pulses", q.size(), 8);
        for (int a = 0; a < 8 && a < q.size(); a++)
            chk("init_pulse", q[a], {1'b0, a[2:0], 1'b1, INIT_VAL});
        for (int a = 0; a < 8; a++) chk("init_mem", mem_model[i][a], INIT_VAL);
        $display("[TB] init sweep inst %0d: %0d strobes", i, q.size());
    endtask

    task automatic do_req(input int i, input bit wr, input logic [2:0] a,
                          input logic [7:0] d, input int hold, output int acc_cyc);
        int k, sel_first, sel_cnt;
        logic [7:0] exp_d, held;
        exp_d        = wr ? d : ref_mem[i][a];
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
        resp_ready[i] = (hold == 0);
        k = 0;
        while (req_ready[i] !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_wait", k < 100, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i]  = 3'($urandom);
        req_wdata[i] = 8'($urandom);
        if (wr) ref_mem[i][a] = d;
        chk("ready_drop", req_ready[i], 0);
        sel_first = 0;
        sel_cnt   = 0;
        k = 1;
        while (resp_valid[i] !== 1'b1 && k < 50) begin
            if (mem_select[i]) begin
                if (sel_first == 0) sel_first = k;
                sel_cnt++;
                chk("strobe_bus", {mem_address[i], mem_op[i]}, {a, wr});
            end
            @(posedge clk); #1;
            k++;
        end
        chk("resp_latency", k, s_of[i] + p_of[i] + 2);
        chk("sel_start", sel_first, s_of[i] + 1);
        chk("sel_width", sel_cnt, p_of[i]);
        chk("resp_rdata", resp_rdata[i], exp_d);
        if (hold > 0) begin
            held = resp_rdata[i];
            req_valid[i] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("hold_valid", resp_valid[i], 1);
                chk("hold_rdata", resp_rdata[i], held);
                chk("hold_ready", req_ready[i], 0);
            end
            req_valid[i]  = 1'b0;
            resp_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        chk("resp_drop", resp_valid[i], 0);
        chk("ready_back", req_ready[i], 1);
        $display("[TB] inst %0d %s addr %0d data %02h -> rdata %02h latency %0d",
                 i, wr ? "WR" : "RD", a, d, exp_d, s_of[i] + p_of[i] + 2);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, k;
        rst_n      = 1'b0;
        mon_en     = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '0;
        prev_sel   = '0;
        prev_bus   = '0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 8; a++) begin
                mem_model[i][a] = 8'($urandom);
                ref_mem[i][a]   = 8'hxx;
            end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Init sweep after reset
        wait_init();
        chk_plog(0);
        chk_plog(1);

        // Write then read back
        do_req(0, 1'b1, 3'd3, 8'hA5, 0, acc1);
        do_req(0, 1'b0, 3'd3, 8'h00, 0, acc1);

        // Response held off for 10 cycles
        do_req(0, 1'b0, 3'd3, 8'h00, 10, acc1);

        // Back-to-back writes: accepts 5 cycles apart
        do_req(0, 1'b1, 3'd7, 8'hFF, 0, acc1);
        do_req(0, 1'b1, 3'd0, 8'h01, 0, acc2);
        chk("accept_spacing", acc2 - acc1, 5);
        do_req(0, 1'b0, 3'd7, 8'h00, 0, acc1);

        // Stretched timing on the second instance
        do_req(1, 1'b1, 3'd2, 8'h5A, 0, acc1);
        do_req(1, 1'b0, 3'd2, 8'h00, 2, acc1);

        // Randomized traffic on both instances
        for (int n = 0; n < 24; n++)
            do_req(n % 2, 1'($urandom), 3'($urandom), 8'($urandom), $urandom_range(0, 3), acc1);

        // Reset in the middle of a strobe
        req_write[0] = 1'b1;
        req_addr[0]  = 3'd5;
        req_wdata[0] = 8'h3C;
        req_valid[0] = 1'b1;
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        k = 0;
        while (mem_select[0] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("strobe_seen", mem_select[0], 1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        plog0.delete();
        plog1.delete();
        mon_en = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wait_init();
        chk_plog(0);
        chk_plog(1);
        do_req(0, 1'b0, 3'd5, 8'h00, 0, acc1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
